// File: rtl/t07_mem_bridge.sv
// t07_mem_bridge: serialises core fetches and loads/stores onto one external memory port.
// Optional feature macro T07_MEM_BRIDGE_IBUF_EN adds a one-entry instruction buffer.
module t07_mem_bridge #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   pc,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [2:0]          funct3,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   store_data,
   output logic [DATA_W-1:0]   instr_out,
   output logic [DATA_W-1:0]   load_data,
   output logic                done,
   output logic                freeze,
   output logic [1:0]          err,
   output logic [ADDR_W-1:0]   ext_addr,
   output logic [DATA_W-1:0]   ext_wdata,
   output logic [DATA_W/8-1:0] ext_be,
   output logic [2:0]          ext_rwi,
   input  logic [DATA_W-1:0]   ext_rdata,
   input  logic                ext_ack
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BE_W - 1);
   localparam logic [2:0] RWI_RD   = 3'b100;
   localparam logic [2:0] RWI_WR   = 3'b010;
   localparam logic [2:0] RWI_IDLE = 3'b001;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_FETCH} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [OFF_W-1:0]  r_off, w_off_nxt, w_off;
   logic [1:0]        r_size, w_size_nxt, w_size;
   logic              r_uns, w_uns_nxt;
   logic [DATA_W-1:0] w_instr_nxt, w_load_nxt, w_wdata_nxt;
   logic [DATA_W-1:0] w_shift, w_mask, w_load_ext;
   logic              w_sign, w_done_nxt;
   logic [1:0]        w_err_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [BE_W-1:0]   w_be_nxt, w_be_req;
   logic [2:0]        w_rwi_nxt;
   logic              w_data_req, w_misalign, w_accept, w_hit;

   assign w_data_req = mem_read | mem_write;
   // Doubleword size collapses to word on a 32-bit port
   assign w_size     = (DATA_W == 32 && funct3[1:0] == 2'b11) ? 2'b10 : funct3[1:0];
   assign w_off      = data_addr[OFF_W-1:0];
   assign w_be_req   = ~({BE_W{1'b1}} << (4'd1 << w_size));
   assign w_accept   = (r_state == S_IDLE) && !done;
   assign w_cnt_inc  = r_cnt + CNT_W'(1);

`ifdef T07_MEM_BRIDGE_IBUF_EN
   logic              r_ibuf_valid;
   logic [ADDR_W-1:0] r_ibuf_tag, r_fetch_pc;
   logic              w_fetch_ok, w_store_acc;

   assign w_hit       = r_ibuf_valid && (pc == r_ibuf_tag);
   assign w_fetch_ok  = (r_state == S_FETCH) && ext_ack;
   assign w_store_acc = w_accept && mem_write && !w_misalign;

   // Tag tracks the last successful fetch; a store to that word drops it
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ibuf_valid <= 1'b0;
         r_ibuf_tag   <= '0;
         r_fetch_pc   <= '0;
      end else begin
         if (w_accept && !w_data_req && inst_req) r_fetch_pc <= pc;
         if (w_fetch_ok) begin
            r_ibuf_valid <= 1'b1;
            r_ibuf_tag   <= r_fetch_pc;
         end else if (w_store_acc && r_ibuf_valid &&
                      ((data_addr & WORD_MASK) == (r_ibuf_tag & WORD_MASK))) begin
            r_ibuf_valid <= 1'b0;
         end
      end
   end
`else
   assign w_hit = 1'b0;
`endif

   always_comb begin
      case (w_size)
         2'd0:    w_misalign = 1'b0;
         2'd1:    w_misalign = data_addr[0];
         2'd2:    w_misalign = |data_addr[1:0];
         default: w_misalign = |data_addr[2:0];
      endcase
   end

   // Load lane extraction: shift down, mask to size, sign/zero extend
   assign w_shift = ext_rdata >> {r_off, 3'b000};
   assign w_mask  = ~({DATA_W{1'b1}} << (7'd8 << r_size));
   always_comb begin
      case (r_size)
         2'd0:    w_sign = w_shift[7];
         2'd1:    w_sign = w_shift[15];
         2'd2:    w_sign = w_shift[31];
         default: w_sign = w_shift[DATA_W-1];
      endcase
   end
   assign w_load_ext = (w_shift & w_mask) | ({DATA_W{w_sign & ~r_uns}} & ~w_mask);

   assign freeze = (r_state != S_IDLE) ||
                   (w_accept && (w_data_req ? !w_misalign : (inst_req && !w_hit)));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_off_nxt   = r_off;
      w_size_nxt  = r_size;
      w_uns_nxt   = r_uns;
      w_instr_nxt = instr_out;
      w_load_nxt  = load_data;
      w_done_nxt  = 1'b0;
      w_err_nxt   = err;
      w_addr_nxt  = ext_addr;
      w_wdata_nxt = ext_wdata;
      w_be_nxt    = ext_be;
      w_rwi_nxt   = ext_rwi;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_data_req) begin
                  if (w_misalign) begin
                     w_err_nxt[0] = 1'b1;
                     w_done_nxt   = 1'b1;
                  end else begin
                     w_addr_nxt  = data_addr & WORD_MASK;
                     w_wdata_nxt = store_data << {w_off, 3'b000};
                     w_be_nxt    = w_be_req << w_off;
                     w_rwi_nxt   = mem_write ? RWI_WR : RWI_RD;
                     w_off_nxt   = w_off;
                     w_size_nxt  = w_size;
                     w_uns_nxt   = funct3[2];
                     w_cnt_nxt   = '0;
                     w_state_nxt = S_DATA;
                  end
               end else if (inst_req) begin
                  if (w_hit) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_addr_nxt  = pc & WORD_MASK;
                     w_be_nxt    = {BE_W{1'b1}};
                     w_rwi_nxt   = RWI_RD;
                     w_cnt_nxt   = '0;
                     w_state_nxt = S_FETCH;
                  end
               end
            end
         end
         default: begin
            if (ext_ack) begin
               if (r_state == S_FETCH)   w_instr_nxt = ext_rdata;
               else if (ext_rwi[2])      w_load_nxt  = w_load_ext;
               w_done_nxt  = 1'b1;
               w_rwi_nxt   = RWI_IDLE;
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
               w_err_nxt[1] = 1'b1;
               w_done_nxt   = 1'b1;
               w_rwi_nxt    = RWI_IDLE;
               w_cnt_nxt    = '0;
               w_state_nxt  = S_IDLE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_off     <= '0;
         r_size    <= '0;
         r_uns     <= 1'b0;
         instr_out <= '0;
         load_data <= '0;
         done      <= 1'b0;
         err       <= '0;
         ext_addr  <= '0;
         ext_wdata <= '0;
         ext_be    <= '0;
         ext_rwi   <= RWI_IDLE;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_off     <= w_off_nxt;
         r_size    <= w_size_nxt;
         r_uns     <= w_uns_nxt;
         instr_out <= w_instr_nxt;
         load_data <= w_load_nxt;
         done      <= w_done_nxt;
         err       <= w_err_nxt;
         ext_addr  <= w_addr_nxt;
         ext_wdata <= w_wdata_nxt;
         ext_be    <= w_be_nxt;
         ext_rwi   <= w_rwi_nxt;
      end
   end
endmodule

// File: tb/tb_t07_mem_bridge.sv
// Bench for t07_mem_bridge: transaction-level model predicts every cycle; directed cases plus random traffic.
module tb_t07_mem_bridge;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0, rst = 1'b0;
   logic        inst_req = 1'b0, mem_read = 1'b0, mem_write = 1'b0, ext_ack = 1'b0;
   logic [31:0] pc = '0, data_addr = '0, store_data = '0, ext_rdata = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] instr_out, load_data, ext_addr, ext_wdata;
   logic        done, freeze;
   logic [1:0]  err;
   logic [3:0]  ext_be;
   logic [2:0]  ext_rwi;

   t07_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .inst_req(inst_req), .pc(pc), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .data_addr(data_addr), .store_data(store_data),
      .instr_out(instr_out), .load_data(load_data), .done(done), .freeze(freeze), .err(err),
      .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_be(ext_be), .ext_rwi(ext_rwi),
      .ext_rdata(ext_rdata), .ext_ack(ext_ack));

   always #5 clk = ~clk;

   int n_checks = 0, n_err = 0;
   logic        exp_valid = 1'b0, exp_freeze, exp_done, chk_ext, chk_wd;
   logic [2:0]  exp_rwi;
   logic [1:0]  exp_err;
   logic [31:0] exp_load, exp_instr, exp_addr, exp_wd;
   logic [3:0]  exp_be;
   // Architectural model state
   logic [1:0]  m_err;
   logic [31:0] m_load, m_instr, m_tag;
   logic        m_ibv;
   // Optional literal pins for the first access cycle
   logic        pin_en = 1'b0, pin_wd_en = 1'b0;
   logic [2:0]  pin_rwi;
   logic [31:0] pin_addr, pin_wd;
   logic [3:0]  pin_be;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_valid) begin
         chk("freeze", 64'(freeze), 64'(exp_freeze));
         chk("done", 64'(done), 64'(exp_done));
         chk("ext_rwi", 64'(ext_rwi), 64'(exp_rwi));
         chk("err", 64'(err), 64'(exp_err));
         chk("load_data", 64'(load_data), 64'(exp_load));
         chk("instr_out", 64'(instr_out), 64'(exp_instr));
         if (chk_ext) begin
            chk("ext_addr", 64'(ext_addr), 64'(exp_addr));
            chk("ext_be", 64'(ext_be), 64'(exp_be));
         end
         if (chk_wd) chk("ext_wdata", 64'(ext_wdata), 64'(exp_wd));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [2:0] f3, input int off);
      int nb;
      logic [63:0] v, m;
      nb = 1 << f3[1:0];
      m  = (64'd1 << (8 * nb)) - 64'd1;
      v  = ({32'd0, rd} >> (8 * off)) & m;
      if (!f3[2] && v[8*nb-1]) v = v | ~m;
      return v[31:0];
   endfunction

   task automatic set_idle_exp();
      exp_freeze = 1'b0; exp_done = 1'b0; exp_rwi = 3'b001;
      chk_ext = 1'b0; chk_wd = 1'b0;
      exp_err = m_err; exp_load = m_load; exp_instr = m_instr;
   endtask

   task automatic model_reset();
      m_err = '0; m_load = '0; m_instr = '0; m_tag = '0; m_ibv = 1'b0;
   endtask

   task automatic idle(input int n);
      mem_read = 1'b0; mem_write = 1'b0; inst_req = 1'b0;
      repeat (n) begin
         ext_ack = 1'($urandom % 2);
         set_idle_exp();
         step();
      end
   endtask

   task automatic access_cycles(input logic [2:0] rwi, input logic [31:0] a, input logic [3:0] be,
                                input logic wr, input logic [31:0] wd, input logic [31:0] rd, input int d);
      int n_acc;
      n_acc = (d < int'(TO)) ? d + 1 : int'(TO);
      for (int i = 0; i < n_acc; i++) begin
         ext_ack   = (i == d);
         ext_rdata = (i == d) ? rd : $urandom;
         set_idle_exp();
         exp_freeze = 1'b1; exp_rwi = rwi; chk_ext = 1'b1; exp_addr = a; exp_be = be;
         chk_wd = wr; exp_wd = wd;
         if (pin_en && i == 0) begin
            #2;
            chk("pin_rwi", 64'(ext_rwi), 64'(pin_rwi));
            chk("pin_addr", 64'(ext_addr), 64'(pin_addr));
            chk("pin_be", 64'(ext_be), 64'(pin_be));
            if (pin_wd_en) chk("pin_wdata", 64'(ext_wdata), 64'(pin_wd));
         end
         step();
      end
   endtask

   task automatic done_cycle();
      ext_ack = 1'($urandom % 2);
      ext_rdata = $urandom;
      set_idle_exp();
      exp_done = 1'b1;
      step();
   endtask

   task automatic data_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rd, input int d, input logic both);
      int nb, off;
      logic mis;
      nb  = 1 << f3[1:0];
      off = int'(addr[1:0]);
      mis = (off % nb) != 0;
      mem_read = ~wr; mem_write = wr; inst_req = both;
      funct3 = f3; data_addr = addr; store_data = sd;
      ext_ack = 1'($urandom % 2);
      set_idle_exp();
      exp_freeze = ~mis;
      step();
      if (mis) begin
         m_err[0] = 1'b1;
      end else begin
         if (wr && m_ibv && (addr >> 2) == (m_tag >> 2)) m_ibv = 1'b0;
         access_cycles(wr ? 3'b010 : 3'b100, addr & 32'hFFFF_FFFC, 4'(((1 << nb) - 1) << off),
                       wr, sd << (8 * off), rd, d);
         if (d < int'(TO)) begin
            if (!wr) m_load = load_model(rd, f3, off);
         end else begin
            m_err[1] = 1'b1;
         end
      end
      done_cycle();
   endtask

   task automatic fetch_txn(input logic [31:0] pcv, input logic [31:0] rd, input int d);
      logic hit;
`ifdef T07_MEM_BRIDGE_IBUF_EN
      hit = m_ibv && (m_tag == pcv);
`else
      hit = 1'b0;
`endif
      mem_read = 1'b0; mem_write = 1'b0; inst_req = 1'b1; pc = pcv;
      ext_ack = 1'($urandom % 2);
      set_idle_exp();
      exp_freeze = ~hit;
      step();
      if (!hit) begin
         access_cycles(3'b100, pcv & 32'hFFFF_FFFC, 4'hF, 1'b0, 32'd0, rd, d);
         if (d < int'(TO)) begin
            m_instr = rd; m_tag = pcv; m_ibv = 1'b1;
         end else begin
            m_err[1] = 1'b1;
         end
      end
      done_cycle();
   endtask

   initial begin
      logic [2:0] ld_f3 [5];
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      model_reset();
      step();
      set_idle_exp();
      chk_ext = 1'b1; exp_addr = '0; exp_be = '0; chk_wd = 1'b1; exp_wd = '0;
      exp_valid = 1'b1;
      step();
      rst = 1'b1;
      idle(2);

      // Fetch at 0x10, ack on the third wait cycle
      pin_en = 1'b1; pin_rwi = 3'b100; pin_addr = 32'h10; pin_be = 4'hF;
      fetch_txn(32'h0000_0010, 32'h0050_0093, 2);
      pin_en = 1'b0;
      chk("fetch_instr", 64'(instr_out), 64'h0050_0093);
      idle(1);

      // Signed and unsigned byte from the top lane
      pin_en = 1'b1; pin_rwi = 3'b100; pin_addr = 32'h100; pin_be = 4'h8;
      data_txn(1'b0, 3'b000, 32'h103, 32'd0, 32'h8000_0000, 0, 1'b0);
      chk("lb_value", 64'(load_data), 64'hFFFF_FF80);
      data_txn(1'b0, 3'b100, 32'h103, 32'd0, 32'h8000_0000, 1, 1'b0);
      pin_en = 1'b0;
      chk("lbu_value", 64'(load_data), 64'h0000_0080);

      // Halfword store into the upper lane
      pin_en = 1'b1; pin_wd_en = 1'b1; pin_rwi = 3'b010; pin_addr = 32'h200; pin_be = 4'hC;
      pin_wd = 32'hBEEF_0000;
      data_txn(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'd0, 1, 1'b0);
      pin_en = 1'b0; pin_wd_en = 1'b0;
      idle(1);

      // Misaligned word load
      data_txn(1'b0, 3'b010, 32'h6, 32'd0, 32'h1234_5678, 0, 1'b0);
      chk("misalign_err", 64'(err), 64'h1);
      chk("misalign_load", 64'(load_data), 64'h80);

      // Load that never gets an ack
      data_txn(1'b0, 3'b010, 32'h40, 32'd0, 32'h1234_5678, int'(TO) + 3, 1'b0);
      chk("timeout_err", 64'(err), 64'h3);
      chk("timeout_load", 64'(load_data), 64'h80);
      idle(2);

      // Data has priority over a simultaneous fetch, fetch follows
      data_txn(1'b0, 3'b010, 32'h20, 32'd0, 32'h1122_3344, 1, 1'b1);
      chk("both_load", 64'(load_data), 64'h1122_3344);
      chk("both_instr_before", 64'(instr_out), 64'h0050_0093);
      fetch_txn(32'h24, 32'h0000_0013, 0);
      chk("both_instr", 64'(instr_out), 64'h0000_0013);
      fetch_txn(32'h24, 32'hDEAD_BEEF, 1);
`ifdef T07_MEM_BRIDGE_IBUF_EN
      chk("refetch_instr", 64'(instr_out), 64'h0000_0013);
`else
      chk("refetch_instr", 64'(instr_out), 64'hDEAD_BEEF);
`endif
      idle(1);

      // Random traffic
      for (int n = 0; n < 200; n++) begin
         int kind, d;
         kind = int'($urandom % 3);
         d    = int'($urandom_range(0, int'(TO) + 1));
         case (kind)
            0: data_txn(1'b0, ld_f3[$urandom % 5], 32'h100 + ($urandom % 32), 32'd0, $urandom, d, 1'b0);
            1: data_txn(1'b1, 3'($urandom % 3), 32'h100 + ($urandom % 32), $urandom, 32'd0, d, 1'b0);
            default: fetch_txn(32'h100 + 4 * ($urandom % 4), $urandom, d);
         endcase
         if ($urandom % 4 == 0) idle(int'($urandom % 3));
      end
      idle(1);

      // Reset in the middle of a load abandons it
      mem_read = 1'b1; mem_write = 1'b0; inst_req = 1'b0; funct3 = 3'b010; data_addr = 32'h40;
      ext_ack = 1'b0;
      set_idle_exp(); exp_freeze = 1'b1;
      step();
      ext_ack = 1'b0;
      set_idle_exp(); exp_freeze = 1'b1; exp_rwi = 3'b100; chk_ext = 1'b1;
      exp_addr = 32'h40; exp_be = 4'hF;
      step();
      rst = 1'b0;
      step();
      mem_read = 1'b0; rst = 1'b1;
      model_reset();
      set_idle_exp();
      chk_ext = 1'b1; exp_addr = '0; exp_be = '0; chk_wd = 1'b1; exp_wd = '0;
      step();
      idle(3);
      chk("post_reset_err", 64'(err), 64'h0);
      fetch_txn(32'h80, 32'hCAFE_0001, 0);
      chk("post_reset_fetch", 64'(instr_out), 64'hCAFE_0001);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/t07_mem_bridge.md
Name: t07_mem_bridge

Overview:
Parametrised successor to the CPU's single-cycle memory handler.
- Serialises instruction fetches and data loads/stores from the t07 core onto one external memory port with a ready/ack handshake.
- Adds byte/half/word sizing with sign extension, misalignment detection, and an ack timeout.
- Drives `freeze` to stall the core while any access is outstanding.
- Sits between the core (PC, control unit, ALU address, register file) and the external memory/SRAM interface.

Parameters:
- ADDR_W, 32, address width of core and external port.
- DATA_W, 32, data width; must be 32 or 64; byte-enable width is DATA_W/8.
- TIMEOUT, 255, maximum wait cycles for `ext_ack` before abort; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset.
- inst_req  in  1  core requests the instruction at `pc`.
- pc  in  ADDR_W  fetch address.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use bits [1:0]).
- data_addr  in  ADDR_W  load/store byte address (ALU result).
- store_data  in  DATA_W  store value, low-aligned.
- instr_out  out  DATA_W  fetched instruction, held until the next fetch completes.
- load_data  out  DATA_W  sized and extended load result, held until the next load completes.
- done  out  1  one-cycle pulse when a core request completes.
- freeze  out  1  stall the core.
- err  out  2  sticky status: bit0 misaligned, bit1 timeout; cleared only by reset.
- ext_addr  out  ADDR_W  word-aligned external address.
- ext_wdata  out  DATA_W  lane-shifted store data.
- ext_be  out  DATA_W/8  byte enables.
- ext_rwi  out  3  one-hot {read, write, idle}; 001 when idle.
- ext_rdata  in  DATA_W  external read data.
- ext_ack  in  1  external access complete this cycle.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State returns to IDLE.
  - instr_out, load_data, ext_addr, ext_wdata, ext_be, timeout counter, err all clear to 0.
  - done=0, freeze=0, ext_rwi=001.
  - Reset mid-access abandons the access with no completion pulse.
- FSM states: IDLE, DATA, FETCH.
- IDLE:
  - If mem_read|mem_write: check alignment. Half needs addr[0]==0; word needs addr[1:0]==0; a 64-bit word needs addr[2:0]==0.
    - Misaligned: set err[0], pulse done next cycle, load_data unchanged, no external access, stay IDLE.
    - Aligned: register address, lanes and data, then go to DATA.
  - Else if inst_req: go to FETCH.
  - Data has priority over fetch when both are requested.
- freeze is combinational:
  - 1 in DATA or FETCH.
  - 1 in IDLE when an aligned request is present and not yet accepted.
  - 0 in the cycle done pulses.
- DATA/FETCH:
  - Drive ext_rwi = 100 (load/fetch) or 010 (store); hold ext_addr and ext_wdata stable.
  - Timeout counter increments each cycle without ack.
  - On ext_ack:
    - Capture data: load data is shifted down by the byte offset, masked to size, then sign- or zero-extended.
    - Pulse done, return to IDLE, clear the counter.
  - If the counter reaches TIMEOUT without ack:
    - Set err[1], pulse done, return to IDLE.
    - Destination register unchanged (load_data/instr_out keep their old value).
- ext_be:
  - Byte: one bit at the offset.
  - Half: two bits.
  - Word: 0xF at the 32-bit lane (0xFF for a 64-bit word).
  - Fetch: full word.
- ext_wdata: store_data shifted left by 8×offset.
- Back-to-back requests: a new request is sampled in the IDLE cycle after done. Minimum access latency is 2 cycles (accept + ack).
- ext_ack while IDLE is ignored.
- Requests deasserted mid-access do not cancel the access.

Optional Feature:
- Macro: T07_MEM_BRIDGE_IBUF_EN.
- Enabled: a one-entry instruction buffer holds a tag (fetch address) plus a valid bit.
  - On a fetch in IDLE whose pc equals the tag while valid: instr_out holds the buffered word and done pulses next cycle without an external access (1-cycle hit, freeze low in that cycle).
  - Any store whose word address equals the tag invalidates the buffer.
  - Reset clears valid.
- Disabled: every fetch goes external; no tag logic is synthesised.

Test Plan:
- Fetch pc=0x0000_0010, ext_ack 3 cycles later with ext_rdata=0x0050_0093:
  - ext_rwi=100, ext_addr=0x10, ext_be=0xF.
  - freeze high for the wait; instr_out=0x0050_0093; done pulses once.
- LB at 0x103 with ext_rdata=0x8000_0000:
  - ext_addr=0x100, ext_be=0x8, load_data=0xFFFF_FF80.
  - Same access as LBU gives load_data=0x0000_0080.
- SH store_data=0x0000_BEEF at 0x202:
  - ext_addr=0x200, ext_be=0xC, ext_wdata=0xBEEF_0000, ext_rwi=010.
- LW at 0x0000_0006:
  - err=01, no ext_rwi activity, done pulses, load_data unchanged.
- Load with no ack and TIMEOUT=4:
  - err[1] set after 4 wait cycles, done pulses, state returns to IDLE.
  - Assert rst=0 mid-access in a second run: all outputs return to reset values next edge.
- mem_read and inst_req together: data access performed first, fetch next. With T07_MEM_BRIDGE_IBUF_EN, a repeated fetch of the same pc completes with no external access.
